// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: data/twiddle widths, ROM phase codes, complex word type.
// Latency: n/a (package only).
// Backpressure: n/a.
package fft_pkg;

    // Signed complex component width used on every SDF stage and twiddle ROM.
    localparam int DATA_W = 24;
    // Twiddle fraction bits: Q.8, so 256 represents 1.0.
    localparam int FRAC_W = 8;

    // Phase reported by the twiddle ROM alongside each twiddle factor.
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_BFLY = 2'd1,
        ST_TWID = 2'd2,
        ST_HOLD = 2'd3
    } sdf_state_t;

    // Complex word shared by the SDF stages and the ROM.
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cmult_q8.sv
// Combinational complex multiply a*b with the product scaled down by FRAC_W (floor, no rounding).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports a_r/a_i/b_r/b_i in, p_r/p_i out, all signed DATA_W.
module cmult_q8 #(
    parameter int DATA_W = 24,
    parameter int FRAC_W = 8
) (
    input  logic signed [DATA_W-1:0] a_r,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_r,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] p_r,
    output logic signed [DATA_W-1:0] p_i
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] rr;
    logic signed [PW-1:0] ii;
    logic signed [PW-1:0] ri;
    logic signed [PW-1:0] ir;
    logic signed [PW-1:0] acc_r;
    logic signed [PW-1:0] acc_i;

    // Operands are sign-extended to the full product width before multiplying
    // so the partial products and their sum never lose the sign.
    always_comb begin
        rr    = PW'(a_r) * PW'(b_r);
        ii    = PW'(a_i) * PW'(b_i);
        ri    = PW'(a_r) * PW'(b_i);
        ir    = PW'(a_i) * PW'(b_r);
        acc_r = rr - ii;
        acc_i = ri + ir;
        // Arithmetic shift floors toward -inf; upper bits are simply dropped.
        p_r   = DATA_W'(acc_r >>> FRAC_W);
        p_i   = DATA_W'(acc_i >>> FRAC_W);
    end

endmodule

// File: rtl/fft_sdf_stage_16.sv
// Radix-2 SDF stage, 16-word feedback: emits butterfly sums, then twiddled differences.
// Latency: 1 clk from the driving state==1/2 cycle to dout; fill cycles produce no output.
// Backpressure: none; 1 word/clk, phase comes from the companion ROM via state/w_r/w_i.
// Ports: clk, rst_n, in_valid, din_r/din_i, state, w_r/w_i in; dout_r/dout_i/out_valid out (registered).
module fft_sdf_stage_16 #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int FRAC_W = fft_pkg::FRAC_W,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] din_r,
    input  logic signed [DATA_W-1:0] din_i,
    input  logic [1:0]               state,
    input  logic signed [DATA_W-1:0] w_r,
    input  logic signed [DATA_W-1:0] w_i,
    output logic signed [DATA_W-1:0] dout_r,
    output logic signed [DATA_W-1:0] dout_i,
    output logic                     out_valid
);

    import fft_pkg::*;

    // Feedback delay line; entry DEPTH-1 is the word pushed DEPTH shifts ago.
    logic signed [DATA_W-1:0] fifo_r [DEPTH];
    logic signed [DATA_W-1:0] fifo_i [DEPTH];

    logic signed [DATA_W-1:0] head_r;
    logic signed [DATA_W-1:0] head_i;
    logic signed [DATA_W-1:0] sum_r;
    logic signed [DATA_W-1:0] sum_i;
    logic signed [DATA_W-1:0] dif_r;
    logic signed [DATA_W-1:0] dif_i;
    logic signed [DATA_W-1:0] push_r;
    logic signed [DATA_W-1:0] push_i;
    logic signed [DATA_W-1:0] tw_r;
    logic signed [DATA_W-1:0] tw_i;
    logic                     shift_en;
    sdf_state_t               st;

    assign st     = sdf_state_t'(state);
    assign head_r = fifo_r[DEPTH-1];
    assign head_i = fifo_i[DEPTH-1];

    // Butterfly: head holds x[n], din carries x[n+DEPTH]; wraps on overflow.
    assign sum_r  = head_r + din_r;
    assign sum_i  = head_i + din_i;
    assign dif_r  = head_r - din_r;
    assign dif_i  = head_i - din_i;

    // What enters the delay line: raw input while filling or during the twiddle
    // phase (next frame's first half, zeros when flushing), the difference while
    // doing butterflies so it re-emerges DEPTH cycles later for twiddling.
    always_comb begin
        shift_en = 1'b0;
        push_r   = din_r;
        push_i   = din_i;
        case (st)
            ST_FILL: shift_en = in_valid;
            ST_BFLY: begin
                shift_en = 1'b1;
                push_r   = dif_r;
                push_i   = dif_i;
            end
            ST_TWID: shift_en = 1'b1;
            default: shift_en = 1'b0;
        endcase
    end

    // During the twiddle phase the head is the stored difference.
    cmult_q8 #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W)
    ) u_cmult (
        .a_r(head_r),
        .a_i(head_i),
        .b_r(w_r),
        .b_i(w_i),
        .p_r(tw_r),
        .p_i(tw_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < DEPTH; n++) begin
                fifo_r[n] <= '0;
                fifo_i[n] <= '0;
            end
        end else if (shift_en) begin
            fifo_r[0] <= push_r;
            fifo_i[0] <= push_i;
            for (int n = 1; n < DEPTH; n++) begin
                fifo_r[n] <= fifo_r[n-1];
                fifo_i[n] <= fifo_i[n-1];
            end
        end
    end

    // Output register: dout holds its last value whenever no word is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r    <= '0;
            dout_i    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (st)
                ST_BFLY: begin
                    dout_r    <= sum_r;
                    dout_i    <= sum_i;
                    out_valid <= 1'b1;
                end
                ST_TWID: begin
                    dout_r    <= tw_r;
                    dout_i    <= tw_i;
                    out_valid <= 1'b1;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage_16.sv
// Bench for the 16-word SDF stage: plays the twiddle ROM, feeds directed and random frames.
// Expected outputs come from a per-frame reference (sums, then twiddled differences).
// Summary line reports the number of comparisons and failures.
module tb_fft_sdf_stage_16;

    import fft_pkg::*;

    localparam int W   = DATA_W;
    localparam int NFR = 6;
    // round(256*cos(2*pi*k/32)), k = 0..15
    localparam int COS_TAB [16] = '{256, 251, 237, 213, 181, 142, 98, 50,
                                    0, -50, -98, -142, -181, -213, -237, -251};

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic signed [W-1:0] din_r;
    logic signed [W-1:0] din_i;
    logic [1:0]          state;
    logic signed [W-1:0] w_r;
    logic signed [W-1:0] w_i;
    logic signed [W-1:0] dout_r;
    logic signed [W-1:0] dout_i;
    logic                out_valid;

    int checks = 0;
    int errors = 0;

    logic signed [W-1:0] fr_r  [NFR][32];
    logic signed [W-1:0] fr_i  [NFR][32];
    logic signed [W-1:0] got_r [NFR][32];
    logic signed [W-1:0] got_i [NFR][32];
    logic signed [W-1:0] exp_r;
    logic signed [W-1:0] exp_i;

    fft_sdf_stage_16 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .din_r    (din_r),
        .din_i    (din_i),
        .state    (state),
        .w_r      (w_r),
        .w_i      (w_i),
        .dout_r   (dout_r),
        .dout_i   (dout_i),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    function automatic int tw_re(input int k);
        return COS_TAB[k];
    endfunction

    // Imag part of exp(-j*2*pi*k/32) is -sin, and sin(k) = cos(|8-k|) on this grid.
    function automatic int tw_im(input int k);
        return -COS_TAB[(k <= 8) ? (8 - k) : (k - 8)];
    endfunction

    // Output j of a frame: j<16 -> x[j]+x[j+16]; j>=16 -> (x[k]-x[k+16])*W32^k scaled by 1/256 (floor).
    function automatic cplx_t ref_out(input int f, input int j);
        cplx_t               y;
        logic signed [W-1:0] d_r;
        logic signed [W-1:0] d_i;
        longint              wc;
        longint              ws;
        longint              pr;
        longint              pim;
        int                  k;
        if (j < 16) begin
            y.re = fr_r[f][j] + fr_r[f][j+16];
            y.im = fr_i[f][j] + fr_i[f][j+16];
        end else begin
            k    = j - 16;
            d_r  = fr_r[f][k] - fr_r[f][k+16];
            d_i  = fr_i[f][k] - fr_i[f][k+16];
            wc   = longint'(tw_re(k));
            ws   = longint'(tw_im(k));
            pr   = longint'(d_r) * wc - longint'(d_i) * ws;
            pim  = longint'(d_r) * ws + longint'(d_i) * wc;
            y.re = W'(pr >>> FRAC_W);
            y.im = W'(pim >>> FRAC_W);
        end
        return y;
    endfunction

    task automatic drive(input logic [1:0] st, input logic v,
                         input logic signed [W-1:0] dr, input logic signed [W-1:0] di,
                         input int k);
        state    = st;
        in_valid = v;
        din_r    = dr;
        din_i    = di;
        if (st == ST_TWID) begin
            w_r = W'(tw_re(k));
            w_i = W'(tw_im(k));
        end else begin
            w_r = W'($urandom);
            w_i = W'($urandom);
        end
    endtask

    task automatic cyc(input logic [1:0] st, input logic v,
                       input logic signed [W-1:0] dr, input logic signed [W-1:0] di,
                       input int k);
        drive(st, v, dr, di, k);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_vld"}, W'(out_valid), W'(1'b0));
        chk({tag, "_r"}, dout_r, exp_r);
        chk({tag, "_i"}, dout_i, exp_i);
    endtask

    task automatic do_out(input int f, input int j);
        cplx_t y;
        y           = ref_out(f, j);
        exp_r       = y.re;
        exp_i       = y.im;
        got_r[f][j] = dout_r;
        got_i[f][j] = dout_i;
        chk($sformatf("out_f%0d_j%0d_vld", f, j), W'(out_valid), W'(1'b1));
        chk($sformatf("out_f%0d_j%0d_r", f, j), dout_r, exp_r);
        chk($sformatf("out_f%0d_j%0d_i", f, j), dout_i, exp_i);
    endtask

    task automatic do_fill(input int f);
        for (int n = 0; n < 16; n++) begin
            cyc(ST_FILL, 1'b1, fr_r[f][n], fr_i[f][n], 0);
            chk_quiet($sformatf("fill_f%0d_n%0d", f, n));
        end
    endtask

    task automatic do_bfly(input int f);
        for (int n = 0; n < 16; n++) begin
            cyc(ST_BFLY, 1'b1, fr_r[f][n+16], fr_i[f][n+16], 0);
            do_out(f, n);
        end
    endtask

    // nxt < 0 means flush with zeros.
    task automatic do_twid(input int f, input int nxt, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            if (nxt >= 0) cyc(ST_TWID, 1'b1, fr_r[nxt][k], fr_i[nxt][k], k);
            else          cyc(ST_TWID, 1'b1, '0, '0, k);
            do_out(f, 16 + k);
        end
    endtask

    initial begin
        // Frames: 0 impulse, 1 DC, 2 half-256, 3 x[1]=-1, 4..5 random full-range.
        for (int f = 0; f < NFR; f++) begin
            for (int n = 0; n < 32; n++) begin
                fr_r[f][n] = '0;
                fr_i[f][n] = '0;
            end
        end
        fr_r[0][0] = W'(256);
        for (int n = 0; n < 32; n++) fr_r[1][n] = W'(100);
        for (int n = 0; n < 16; n++) fr_r[2][n] = W'(256);
        fr_r[3][1] = W'(-1);
        for (int f = 4; f < NFR; f++) begin
            for (int n = 0; n < 32; n++) begin
                fr_r[f][n] = W'($urandom);
                fr_i[f][n] = W'($urandom);
            end
        end

        // Reset held across clock edges.
        rst_n = 1'b0;
        drive(ST_FILL, 1'b0, '0, '0, 0);
        exp_r = '0;
        exp_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;

        // Idle cycles with in_valid low: nothing emitted, nothing captured.
        for (int n = 0; n < 3; n++) begin
            cyc(ST_FILL, 1'b0, W'($urandom), W'($urandom), 0);
            chk_quiet($sformatf("idle%0d", n));
        end

        // Back-to-back frames, then a zero flush.
        do_fill(0);
        for (int f = 0; f < NFR; f++) begin
            do_bfly(f);
            do_twid(f, (f < NFR - 1) ? f + 1 : -1, 16);
        end

        // Known spectra.
        chk("imp_x0_r",    got_r[0][0],  W'(256));
        chk("imp_x0_i",    got_i[0][0],  W'(0));
        chk("imp_sum5_r",  got_r[0][5],  W'(0));
        chk("imp_d0_r",    got_r[0][16], W'(256));
        chk("imp_d0_i",    got_i[0][16], W'(0));
        chk("imp_d1_r",    got_r[0][17], W'(0));
        chk("dc_sum0_r",   got_r[1][0],  W'(200));
        chk("dc_sum15_r",  got_r[1][15], W'(200));
        chk("dc_d0_r",     got_r[1][16], W'(0));
        chk("dc_d9_i",     got_i[1][25], W'(0));
        chk("tw_sum0_r",   got_r[2][0],  W'(256));
        chk("tw_k1_r",     got_r[2][17], W'(251));
        chk("tw_k1_i",     got_i[2][17], W'(-50));
        chk("tw_k8_r",     got_r[2][24], W'(0));
        chk("tw_k8_i",     got_i[2][24], W'(-256));
        chk("tw_k15_r",    got_r[2][31], W'(-251));
        chk("tw_k15_i",    got_i[2][31], W'(-50));
        chk("neg_k1_r",    got_r[3][17], W'(-1));
        chk("neg_k1_i",    got_i[3][17], W'(0));

        // Mid-operation reset: DC frame, drop rst_n inside the 5th twiddle cycle.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_r = '0;
        exp_i = '0;
        drive(ST_FILL, 1'b0, '0, '0, 0);
        @(posedge clk);
        #1;
        do_fill(1);
        do_bfly(1);
        do_twid(1, -1, 4);
        drive(ST_TWID, 1'b1, '0, '0, 4);
        #3;
        rst_n = 1'b0;
        #1;
        exp_r = '0;
        exp_i = '0;
        chk_quiet("midrst_async");
        drive(ST_FILL, 1'b0, '0, '0, 0);
        @(posedge clk);
        #1;
        chk_quiet("midrst_held");
        rst_n = 1'b1;

        // Restart: fresh fill, then the DC sums again.
        do_fill(1);
        do_bfly(1);
        do_twid(1, -1, 16);
        chk("rst_dc_sum0_r", got_r[1][0], W'(200));
        chk("rst_dc_sum0_i", got_i[1][0], W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
